// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer.
// Owns the PC register and next-PC selection: sequential step, branch/jump
// redirect, trap vector; plus stall, halt/resume, misaligned-target trap,
// exception-PC capture and a saturating redirect counter.
// Optional feature macro: PC_COMPRESSED_EN (adds is_compressed, +2 stepping,
// target alignment checked on bit 0 only).
module pc_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             trap_req,
  input  logic             halt_req,
  input  logic             resume,
`ifdef PC_COMPRESSED_EN
  input  logic             is_compressed,
`endif
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus_inc,
  output logic             pc_valid,
  output logic             misaligned,
  output logic [XLEN-1:0]  epc,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [XLEN-1:0]  pc_n, epc_n, step;
  logic [CNT_W-1:0] cnt_n;
  logic             mis_n, target_bad, redirect;

  // Sequential step size and target alignment rule
`ifdef PC_COMPRESSED_EN
  always_comb begin
    step       = is_compressed ? XLEN'(2) : XLEN'(INC);
    target_bad = branch_target[0];
  end
`else
  always_comb begin
    step       = XLEN'(INC);
    target_bad = |branch_target[1:0];
  end
`endif

  assign pc_plus_inc = pc + step;
  assign pc_valid    = (state == RUN);

  // Next-state / next-PC selection; redirects outrank halt and stall
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    epc_n    = epc;
    cnt_n    = redirect_cnt;
    mis_n    = 1'b0;
    redirect = 1'b0;
    unique case (state)
      BOOT: state_n = RUN;
      RUN: begin
        if (trap_req) begin
          pc_n     = TRAP_VECTOR;
          epc_n    = pc;
          redirect = 1'b1;
        end else if (branch_taken) begin
          redirect = 1'b1;
          if (target_bad) begin
            pc_n  = TRAP_VECTOR;
            epc_n = pc;
            mis_n = 1'b1;
          end else begin
            pc_n = branch_target;
          end
        end else if (halt_req) begin
          state_n = HALT;
        end else if (!stall) begin
          pc_n = pc_plus_inc;
        end
      end
      HALT: if (resume) state_n = RUN;
      default: state_n = BOOT;
    endcase
    if (redirect && (redirect_cnt != '1)) cnt_n = redirect_cnt + CNT_W'(1);
  end

  // State and architectural registers, asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= BOOT;
      pc           <= RESET_VECTOR;
      epc          <= '0;
      redirect_cnt <= '0;
      misaligned   <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      epc          <= epc_n;
      redirect_cnt <= cnt_n;
      misaligned   <= mis_n;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pc_sequencer;

  localparam int unsigned CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0, branch_taken = 1'b0, trap_req = 1'b0;
  logic          halt_req = 1'b0, resume = 1'b0, is_compressed = 1'b0;
  logic [31:0]   branch_target = '0;
  logic [31:0]   pc, pc_plus_inc, epc;
  logic          pc_valid, misaligned;
  logic [CW-1:0] redirect_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Behavioural model of architectural state
  logic [31:0] m_pc = 32'h0, m_epc = 32'h0;
  int          m_cnt = 0;
  bit          m_mis = 1'b0, m_boot = 1'b1, m_halt = 1'b0;

  pc_sequencer #(
    .XLEN(32), .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100),
    .INC(4), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .trap_req(trap_req), .halt_req(halt_req),
    .resume(resume),
`ifdef PC_COMPRESSED_EN
    .is_compressed(is_compressed),
`endif
    .pc(pc), .pc_plus_inc(pc_plus_inc), .pc_valid(pc_valid),
    .misaligned(misaligned), .epc(epc), .redirect_cnt(redirect_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_step(input bit comp);
`ifdef PC_COMPRESSED_EN
    return comp ? 32'd2 : 32'd4;
`else
    return 32'd4;
`endif
  endfunction

  function automatic bit m_bad_target(input logic [31:0] t);
`ifdef PC_COMPRESSED_EN
    return t[0];
`else
    return t[1:0] != 2'b00;
`endif
  endfunction

  task automatic m_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_cnt = 0; m_mis = 1'b0;
    m_boot = 1'b1; m_halt = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model by the rules, wait the edge
  task automatic cycle(input bit s, input bit b, input logic [31:0] t,
                       input bit tr, input bit h, input bit r, input bit c);
    logic [31:0] npc, nepc;
    int          ncnt;
    bit          nmis, nboot, nhalt;
    stall = s; branch_taken = b; branch_target = t; trap_req = tr;
    halt_req = h; resume = r; is_compressed = c;
    npc = m_pc; nepc = m_epc; ncnt = m_cnt; nmis = 1'b0;
    nboot = m_boot; nhalt = m_halt;
    if (m_boot) nboot = 1'b0;
    else if (m_halt) begin
      if (r) nhalt = 1'b0;
    end else if (tr || b) begin
      if (!tr && !m_bad_target(t)) npc = t;
      else begin
        npc = 32'h100; nepc = m_pc; nmis = !tr;
      end
      ncnt = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
    end else if (h) nhalt = 1'b1;
    else if (!s) npc = m_pc + m_step(c);
    @(posedge clock);
    #1;
    m_pc = npc; m_epc = nepc; m_cnt = ncnt; m_mis = nmis;
    m_boot = nboot; m_halt = nhalt;
  endtask

  task automatic idle(input bit c);
    cycle(0, 0, 32'h0, 0, 0, 0, c);
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clock) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("pc_plus_inc", pc_plus_inc, m_pc + m_step(is_compressed));
      chk("pc_valid", 32'(pc_valid), 32'(!m_boot && !m_halt));
      chk("misaligned", 32'(misaligned), 32'(m_mis));
      chk("epc", epc, m_epc);
      chk("redirect_cnt", 32'(redirect_cnt), 32'(m_cnt));
    end
  end

  initial begin
    m_reset();
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(pc_valid), 32'h0);
    chk("rst_cnt", 32'(redirect_cnt), 32'h0);
    chk("rst_epc", epc, 32'h0);
    @(negedge clock); #2 reset = 1'b1;
    chk_en = 1'b1;

    // Boot then sequential stepping
    idle(0); chk("boot_pc", pc, 32'h0); chk("boot_valid", 32'(pc_valid), 32'h1);
    idle(0); chk("seq4", pc, 32'h4);
    idle(0); idle(0); chk("seqC", pc, 32'hC);
    idle(0); chk("seq10", pc, 32'h10);

    // Stall, then branch overriding stall
    cycle(1, 0, 32'h0, 0, 0, 0, 0);
    cycle(1, 0, 32'h0, 0, 0, 0, 0); chk("stall_pc", pc, 32'h10);
    cycle(1, 1, 32'h200, 0, 0, 0, 0);
    chk("br_stall_pc", pc, 32'h200); chk("br_stall_cnt", 32'(redirect_cnt), 32'h1);

    // Misaligned target
    cycle(0, 1, 32'h40, 0, 0, 0, 0);
    cycle(0, 1, 32'h202, 0, 0, 0, 0);
    chk("mis_pc", pc, 32'h100); chk("mis_epc", epc, 32'h40);
    chk("mis_flag", 32'(misaligned), 32'h1); chk("mis_cnt", 32'(redirect_cnt), 32'h3);
    idle(0); chk("mis_clear", 32'(misaligned), 32'h0); chk("mis_next_pc", pc, 32'h104);

    // Trap beats branch
    cycle(0, 1, 32'h80, 0, 0, 0, 0);
    cycle(0, 1, 32'h300, 1, 0, 0, 0);
    chk("trap_pc", pc, 32'h100); chk("trap_epc", epc, 32'h80);
    chk("trap_mis", 32'(misaligned), 32'h0); chk("trap_cnt", 32'(redirect_cnt), 32'h5);

    // Halt / resume with wraparound
    cycle(0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0);
    cycle(0, 0, 32'h0, 0, 1, 0, 0);
    chk("halt_pc", pc, 32'hFFFF_FFF8); chk("halt_valid", 32'(pc_valid), 32'h0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'h500, 1, 1, 0, 0);
    chk("halt_frozen", pc, 32'hFFFF_FFF8); chk("halt_cnt", 32'(redirect_cnt), 32'h6);
    cycle(0, 0, 32'h0, 0, 0, 1, 0);
    chk("resume_pc", pc, 32'hFFFF_FFF8); chk("resume_valid", 32'(pc_valid), 32'h1);
    idle(0); chk("wrap_fc", pc, 32'hFFFF_FFFC);
    idle(0); chk("wrap_0", pc, 32'h0);

    // Asynchronous reset while halted
    cycle(0, 1, 32'h1000, 0, 0, 0, 0);
    cycle(0, 0, 32'h0, 0, 1, 0, 0);
    @(posedge clock); #2 reset = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0); chk("arst_cnt", 32'(redirect_cnt), 32'h0);
    chk("arst_valid", 32'(pc_valid), 32'h0);
    m_reset();
    @(negedge clock); #2 reset = 1'b1;
    idle(0);

`ifdef PC_COMPRESSED_EN
    cycle(0, 1, 32'h20, 0, 0, 0, 0);
    idle(1); chk("c_step", pc, 32'h22);
    cycle(0, 1, 32'h203, 0, 0, 0, 0);
    chk("c_mis_pc", pc, 32'h100); chk("c_mis_flag", 32'(misaligned), 32'h1);
    cycle(0, 1, 32'h202, 0, 0, 0, 0);
    chk("c_aligned", pc, 32'h202); chk("c_aligned_mis", 32'(misaligned), 32'h0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      cycle($urandom_range(3) == 0, $urandom_range(3) == 0, t,
            $urandom_range(15) == 0, $urandom_range(19) == 0,
            $urandom_range(2) == 0, $urandom_range(1) == 0);
    end
    chk("cnt_saturated", 32'(redirect_cnt), 32'hF);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
